// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point DCT datapath.
// Contents:
//   DW, CW          - default sample / coefficient widths
//   ACC_W, PROD_W   - dot-product accumulator and product widths
//   RND, SHIFT      - round constant and output shift (Q7 x Q7 / 8 scaling)
//   C1..C7          - Q7 cosine constants
//   cos_coef(k, n)  - signed basis value C(k,n), shared with the forward transform
//   state_t         - row FSM states
package dct_pkg;

  localparam int DW     = 8;
  localparam int CW     = 12;
  localparam int PROD_W = 22;
  localparam int ACC_W  = 25;
  localparam int RND    = 4096;
  localparam int SHIFT  = 13;

  localparam logic signed [7:0] C1 = 8'sd126;
  localparam logic signed [7:0] C2 = 8'sd118;
  localparam logic signed [7:0] C3 = 8'sd106;
  localparam logic signed [7:0] C4 = 8'sd91;
  localparam logic signed [7:0] C5 = 8'sd71;
  localparam logic signed [7:0] C6 = 8'sd49;
  localparam logic signed [7:0] C7 = 8'sd25;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  function automatic logic signed [7:0] cos_q7(input logic [2:0] idx);
    logic signed [7:0] c;
    case (idx)
      3'd1:    c = C1;
      3'd2:    c = C2;
      3'd3:    c = C3;
      3'd4:    c = C4;
      3'd5:    c = C5;
      3'd6:    c = C6;
      3'd7:    c = C7;
      default: c = 8'sd0;
    endcase
    return c;
  endfunction

  // C(k,n) = Q7 cos((2n+1)k*pi/16); the angle index is folded into [0,16]
  // so only the first-quadrant constants are stored.
  function automatic logic signed [7:0] cos_coef(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] j;
    logic [4:0] jf;
    logic signed [7:0] c;
    // 5-bit product wraps the angle index modulo 32 for free
    j  = {1'b0, n, 1'b1} * {2'b00, k};
    jf = (j > 5'd16) ? (5'd0 - j) : j;
    if (k == 3'd0)
      c = C4;
    else if (jf == 5'd8)
      c = 8'sd0;
    else if (jf < 5'd8)
      c = cos_q7(jf[2:0]);
    else
      c = -cos_q7(3'(5'd16 - jf));
    return c;
  endfunction

endpackage

// File: rtl/idct_mac8.sv
// Combinational 8-term dot product for one IDCT output sample.
// Ports:
//   coef     in  8*CW  coefficients y0..y7, y0 in the MSBs
//   dc_scale in  1     y0 is in coarse DC units (scaled up by 4 before use)
//   n        in  3     output sample index
//   sample   out DW    rounded, saturated x_n
module idct_mac8
  import dct_pkg::*;
#(
  parameter int DW = dct_pkg::DW,
  parameter int CW = dct_pkg::CW
) (
  input  logic [8*CW-1:0]     coef,
  input  logic                dc_scale,
  input  logic [2:0]          n,
  output logic signed [DW-1:0] sample
);

  localparam int YW = CW + 2;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (DW - 1)));

  function automatic logic signed [DW-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + ACC_W'(RND)) >>> SHIFT;
    if (r > SAT_HI)
      return {1'b0, {(DW - 1){1'b1}}};
    else if (r < SAT_LO)
      return {1'b1, {(DW - 1){1'b0}}};
    else
      return r[DW-1:0];
  endfunction

  logic signed [ACC_W-1:0]  acc;
  logic signed [YW-1:0]     ys;
  logic signed [PROD_W-1:0] prod;

  always_comb begin
    acc  = '0;
    ys   = '0;
    prod = '0;
    for (int k = 0; k < 8; k++) begin
      ys = YW'(signed'(coef[(7 - k) * CW +: CW]));
      if (k == 0 && dc_scale)
        ys = ys <<< 2;
      prod = PROD_W'(ys) * PROD_W'(cos_coef(3'(k), n));
      acc  = acc + ACC_W'(prod);
    end
    sample = round_sat(acc);
  end

endmodule

// File: rtl/idct_8pt_row.sv
// Sequential 8-point row IDCT: accepts one coefficient row, computes one
// output sample per cycle through a shared dot-product unit, then presents
// the full row until downstream accepts it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   coef_in   in  8*CW    y0..y7 (y0 in MSBs)
//   dc_scale  in  1       y0 was produced in coarse DC mode
//   in_valid  in  1 / in_ready  out 1   input handshake (accept only in IDLE)
//   data_out  out 8*DW    x0..x7 (x0 in MSBs)
//   out_valid out 1 / out_ready in  1   output handshake
module idct_8pt_row
  import dct_pkg::*;
#(
  parameter int DW = dct_pkg::DW,
  parameter int CW = dct_pkg::CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8*CW-1:0]   coef_in,
  input  logic              dc_scale,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [8*DW-1:0]   data_out,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t state, state_nxt;
  logic [2:0]           n;
  logic [8*CW-1:0]      coef_q;
  logic                 dc_q;
  logic signed [DW-1:0] sample;
  logic signed [DW-1:0] row_q [8];

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = CALC;
      CALC:    if (n == 3'd7)  state_nxt = OUT;
      OUT:     if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
  end

  // ---- coefficient capture ----
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      coef_q <= coef_in;
      dc_q   <= dc_scale;
    end
  end

  idct_mac8 #(.DW(DW), .CW(CW)) u_mac (
    .coef     (coef_q),
    .dc_scale (dc_q),
    .n        (n),
    .sample   (sample)
  );

  // ---- per-sample writeback ----
  // n wraps 7 -> 0 on the last CALC cycle, so it is already 0 for the next row.
  always_ff @(posedge clk) begin
    if (rst) begin
      n <= 3'd0;
      for (int i = 0; i < 8; i++)
        row_q[i] <= '0;
    end else begin
      if (state == IDLE && in_valid)
        n <= 3'd0;
      if (state == CALC) begin
        row_q[n] <= sample;
        n        <= n + 3'd1;
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < 8; i++)
      data_out[(7 - i) * DW +: DW] = row_q[i];
  end

endmodule

// File: tb/tb_idct_8pt_row.sv
// Scoreboard bench for idct_8pt_row. Expected rows come from a floating-point
// cosine reference (rounded to Q7) and a forward-DCT model for round trips.
module tb_idct_8pt_row;

  localparam int DW = 8;
  localparam int CW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [8*CW-1:0] coef_in;
  logic            dc_scale;
  logic            in_valid;
  logic            in_ready;
  logic [8*DW-1:0] data_out;
  logic            out_valid;
  logic            out_ready;

  logic force_ready = 1'b1;
  logic rand_ready  = 1'b0;
  logic rnd_bit     = 1'b1;

  assign out_ready = rand_ready ? rnd_bit : force_ready;

  always #5 clk = ~clk;

  idct_8pt_row #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .coef_in   (coef_in),
    .dc_scale  (dc_scale),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef int row_t [8];
  typedef struct {
    logic [63:0] exp;
    int          tol;
    int          id;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec   = 0;
  int  n_bad   = 0;
  int  cyc     = 0;
  int  acc_cyc = -100;
  int  next_id = 0;
  logic ov_prev = 1'b0;
  sb_t  cur;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // ---------------- reference model ----------------
  function automatic int cmodel(int k, int n);
    real v;
    if (k == 0) return 91;
    v = 128.0 * $cos(3.14159265358979 * real'((2 * n + 1) * k) / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [63:0] idct_model(input row_t y, input bit dc);
    logic [63:0] r;
    longint acc;
    int x, yk;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) begin
        yk  = (k == 0 && dc) ? y[0] * 4 : y[k];
        acc = acc + longint'(yk) * longint'(cmodel(k, n));
      end
      x = $rtoi($floor(real'(acc + 4096) / 8192.0));
      if (x > 127)  x = 127;
      if (x < -128) x = -128;
      r[(7 - n) * 8 +: 8] = x[7:0];
    end
    return r;
  endfunction

  function automatic void fdct_model(input row_t x, output row_t y);
    real v;
    int s;
    for (int k = 0; k < 8; k++) begin
      s = 0;
      for (int n = 0; n < 8; n++) s += x[n] * cmodel(k, n);
      v = real'(s) / 8.0;
      y[k] = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
      if (y[k] > 2047)  y[k] = 2047;
      if (y[k] < -2048) y[k] = -2048;
    end
  endfunction

  function automatic logic [8*CW-1:0] pack12(input row_t y);
    logic [8*CW-1:0] c;
    for (int k = 0; k < 8; k++) c[(7 - k) * CW +: CW] = y[k][CW-1:0];
    return c;
  endfunction

  function automatic logic [63:0] pack8(input row_t x);
    logic [63:0] r;
    for (int n = 0; n < 8; n++) r[(7 - n) * 8 +: 8] = x[n][7:0];
    return r;
  endfunction

  function automatic bit row_match(logic [63:0] got, logic [63:0] exp, int tol);
    int g, e, d;
    for (int i = 0; i < 8; i++) begin
      g = int'($signed(got[i * 8 +: 8]));
      e = int'($signed(exp[i * 8 +: 8]));
      d = g - e;
      if (d > tol || d < -tol) return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) acc_cyc = cyc + 1;
    if (!rst && out_valid && !ov_prev) begin
      n_vec++;
      if (cyc - acc_cyc != 8) begin
        n_bad++;
        $display("FAIL latency got=%0d want=8", cyc - acc_cyc);
      end
    end
    ov_prev = out_valid;
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_row got=%h want=none", data_out);
      end else begin
        cur = sb_q.pop_front();
        if (!row_match(data_out, cur.exp, cur.tol)) begin
          n_bad++;
          $display("FAIL row%0d got=%h want=%h tol=%0d", cur.id, data_out, cur.exp, cur.tol);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [8*CW-1:0] c, input bit dc);
    int t;
    coef_in  = c;
    dc_scale = dc;
    in_valid = 1'b1;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 300) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout got=busy want=in_ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_in  = {$urandom, $urandom, $urandom};
  endtask

  task automatic issue(input row_t y, input bit dc, input logic [63:0] exp, input int tol);
    sb_t e;
    e.exp = exp;
    e.tol = tol;
    e.id  = next_id;
    next_id++;
    sb_q.push_back(e);
    send(pack12(y), dc);
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    if (t == 3000) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout got=%0d want=0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    row_t y, x;
    bit dc;
    logic [63:0] snap;
    int t;

    rst = 1'b1; in_valid = 1'b0; coef_in = '0; dc_scale = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out",  data_out,       64'd0);
    rst = 1'b0;

    y = '{0, 0, 0, 0, 0, 0, 0, 0};
    issue(y, 1'b0, 64'h0, 0);
    y = '{910, 0, 0, 0, 0, 0, 0, 0};
    issue(y, 1'b0, 64'h0A0A0A0A0A0A0A0A, 0);
    y = '{227, 0, 0, 0, 0, 0, 0, 0};
    issue(y, 1'b1, 64'h0A0A0A0A0A0A0A0A, 0);
    issue(y, 1'b0, 64'h0303030303030303, 0);
    y = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    issue(y, 1'b0, idct_model(y, 1'b0), 0);
    y = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    issue(y, 1'b0, idct_model(y, 1'b0), 0);
    drain();
    check("sat_x0_pos_row", 64'(idct_model('{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047}, 1'b0) >> 56), 64'h7F);

    // random coefficient rows with random downstream back-pressure
    rand_ready = 1'b1;
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 8; k++) y[k] = int'($urandom_range(0, 4095)) - 2048;
      dc = $urandom_range(0, 1) != 0;
      issue(y, dc, idct_model(y, dc), 0);
    end
    // round trip through the forward model
    for (int r = 0; r < 16; r++) begin
      for (int n = 0; n < 8; n++) x[n] = int'($urandom_range(0, 40)) - 20;
      fdct_model(x, y);
      issue(y, 1'b0, pack8(x), 1);
    end
    drain();
    rand_ready  = 1'b0;
    force_ready = 1'b1;

    // output held under back-pressure
    force_ready = 1'b0;
    for (int k = 0; k < 8; k++) y[k] = int'($urandom_range(0, 1023)) - 512;
    issue(y, 1'b0, idct_model(y, 1'b0), 0);
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (t == 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL hold_wait got=no_valid want=out_valid");
    end
    snap = data_out;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_data",      data_out,       snap);
      check("hold_in_ready",  64'(in_ready),  64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    force_ready = 1'b1;
    drain();

    // reset in the fourth CALC cycle; in_valid during reset must be ignored
    y = '{910, 0, 0, 0, 0, 0, 0, 0};
    send(pack12(y), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    coef_in  = pack12(y);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_data_out",  data_out,       64'd0);
    for (int k = 0; k < 8; k++) y[k] = int'($urandom_range(0, 4095)) - 2048;
    issue(y, 1'b1, idct_model(y, 1'b1), 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
